// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM controller: command encodings, FSM states,
// timing defaults and the mode-register word.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_WAIT,
    ST_INIT_REF,
    ST_LOAD_MODE,
    ST_IDLE,
    ST_WRITE,
    ST_ACT2,
    ST_READ,
    ST_CAPTURE
  } state_t;

  localparam int          DEF_INIT_WAIT_CYC  = 20000;
  localparam int          DEF_T_RP           = 2;
  localparam int          DEF_T_RFC          = 7;
  localparam int          DEF_T_MRD          = 2;
  localparam int          DEF_T_RCD          = 2;
  localparam int          DEF_CAS_LAT        = 2;
  localparam int          DEF_INIT_REFRESHES = 2;
  localparam int          DEF_REFRESH_CYC    = 780;
  localparam logic [15:0] DEF_TEST_PATTERN   = 16'hA5A5;

  // A10 high: precharge-all / auto-precharge on column commands
  localparam logic [13:0] ADDR_AUTO_PRE = 14'h0400;

  // Burst length 1, sequential, burst write; only the CAS latency field is non-zero.
  function automatic logic [13:0] mode_word(input int cas_lat);
    mode_word = 14'(cas_lat) << 4;
  endfunction

endpackage

// File: rtl/sdram_timer.sv
// Elapsed-cycle timer shared by every controller wait: cleared on state entry,
// counts each clock, and flags when the requested cycle count has been reached.
module sdram_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == limit);

endmodule

// File: rtl/sdram.sv
// SDR SDRAM controller core: power-up init, periodic auto-refresh and a single
// built-in write/read-back of a fixed word at bank 0 / row 0 / col 0.
module sdram
  import sdram_pkg::*;
#(
  parameter int          INIT_WAIT_CYC  = DEF_INIT_WAIT_CYC,
  parameter int          T_RP           = DEF_T_RP,
  parameter int          T_RFC          = DEF_T_RFC,
  parameter int          T_MRD          = DEF_T_MRD,
  parameter int          T_RCD          = DEF_T_RCD,
  parameter int          CAS_LAT        = DEF_CAS_LAT,
  parameter int          INIT_REFRESHES = DEF_INIT_REFRESHES,
  parameter int          REFRESH_CYC    = DEF_REFRESH_CYC,
  parameter logic [15:0] TEST_PATTERN   = DEF_TEST_PATTERN
) (
  input  logic        clk,
  input  logic        rst,
  output logic        clk_EN,
  output logic [13:0] SDRAM_Addr,
  output logic [1:0]  SDRAM_BankAddr,
  inout  wire  [15:0] SDRAM_data,
  output logic        SDRAM_WE,
  output logic        SDRAM_CHIP_Sel,
  output logic        SDRAM_RAS,
  output logic        SDRAM_CAS
);

  localparam int TW = $clog2(INIT_WAIT_CYC + 1);
  // Headroom so a refresh delayed by the test sequence cannot wrap the counter
  localparam int RW = $clog2(REFRESH_CYC + 64);
  localparam int IW = $clog2(INIT_REFRESHES + 1);

  state_t        state_reg, state_next;
  state_t        after_reg, after_next;
  logic [3:0]    cmd_reg, cmd_next;
  logic [13:0]   addr_reg, addr_next;
  logic [1:0]    ba_reg, ba_next;
  logic          dq_oe_reg, dq_oe_next;
  logic          cke_reg;
  logic [TW-1:0] wait_lim_reg, wait_lim_next;
  logic [RW-1:0] ref_cnt_reg;
  logic [IW-1:0] init_ref_cnt_reg, init_ref_next;
  logic          init_done_reg, init_done_next;
  logic          test_done_reg, test_done_next;
  logic          capture_reg;
  logic [15:0]   rd_word_reg;
  logic          test_pass_reg;

  logic          timer_clr, timer_done, ref_clr, ref_due, capture;
  logic [TW-1:0] timer_limit;

  assign timer_limit = (state_reg == ST_INIT_WAIT) ? TW'(INIT_WAIT_CYC - 1) : wait_lim_reg;
  assign ref_due     = (ref_cnt_reg >= RW'(REFRESH_CYC - 1));

  sdram_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .limit (timer_limit),
    .done  (timer_done)
  );

  // Wait limits are programmed as T-1 so that T NOP cycles separate consecutive commands.
  always_comb begin
    state_next     = state_reg;
    after_next     = after_reg;
    cmd_next       = CMD_NOP;
    addr_next      = '0;
    ba_next        = '0;
    dq_oe_next     = 1'b0;
    wait_lim_next  = wait_lim_reg;
    timer_clr      = 1'b0;
    init_ref_next  = init_ref_cnt_reg;
    init_done_next = init_done_reg;
    test_done_next = test_done_reg;
    ref_clr        = !init_done_reg;
    capture        = 1'b0;
    case (state_reg)
      ST_INIT_WAIT: begin
        if (timer_done) begin
          cmd_next      = CMD_PRECHARGE;
          addr_next     = ADDR_AUTO_PRE;
          wait_lim_next = TW'(T_RP - 1);
          after_next    = ST_INIT_REF;
        end
      end
      ST_WAIT: begin
        if (timer_done) state_next = after_reg;
      end
      ST_INIT_REF: begin
        cmd_next      = CMD_REFRESH;
        init_ref_next = init_ref_cnt_reg + 1'b1;
        wait_lim_next = TW'(T_RFC - 1);
        after_next    = (init_ref_cnt_reg == IW'(INIT_REFRESHES - 1)) ? ST_LOAD_MODE : ST_INIT_REF;
      end
      ST_LOAD_MODE: begin
        cmd_next      = CMD_LOAD_MODE;
        addr_next     = mode_word(CAS_LAT);
        wait_lim_next = TW'(T_MRD - 1);
        after_next    = ST_IDLE;
      end
      ST_IDLE: begin
        init_done_next = 1'b1;
        // Refresh wins over the one-shot test when both are pending
        if (init_done_reg && ref_due) begin
          cmd_next      = CMD_REFRESH;
          ref_clr       = 1'b1;
          wait_lim_next = TW'(T_RFC - 1);
          after_next    = ST_IDLE;
        end else if (!test_done_reg) begin
          cmd_next       = CMD_ACTIVE;
          test_done_next = 1'b1;
          wait_lim_next  = TW'(T_RCD - 1);
          after_next     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cmd_next      = CMD_WRITE;
        addr_next     = ADDR_AUTO_PRE;
        dq_oe_next    = 1'b1;
        wait_lim_next = TW'(T_RP + 2 - 1);
        after_next    = ST_ACT2;
      end
      ST_ACT2: begin
        cmd_next      = CMD_ACTIVE;
        wait_lim_next = TW'(T_RCD - 1);
        after_next    = ST_READ;
      end
      ST_READ: begin
        cmd_next      = CMD_READ;
        addr_next     = ADDR_AUTO_PRE;
        wait_lim_next = TW'(CAS_LAT - 1);
        after_next    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_INIT_WAIT;
    endcase
    if (cmd_next != CMD_NOP) begin
      state_next = ST_WAIT;
      timer_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_INIT_WAIT;
      after_reg        <= ST_INIT_WAIT;
      cmd_reg          <= 4'b1111;
      addr_reg         <= '0;
      ba_reg           <= '0;
      dq_oe_reg        <= 1'b0;
      cke_reg          <= 1'b0;
      wait_lim_reg     <= '0;
      ref_cnt_reg      <= '0;
      init_ref_cnt_reg <= '0;
      init_done_reg    <= 1'b0;
      test_done_reg    <= 1'b0;
      capture_reg      <= 1'b0;
      rd_word_reg      <= '0;
      test_pass_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      after_reg        <= after_next;
      cmd_reg          <= cmd_next;
      addr_reg         <= addr_next;
      ba_reg           <= ba_next;
      dq_oe_reg        <= dq_oe_next;
      cke_reg          <= 1'b1;
      wait_lim_reg     <= wait_lim_next;
      ref_cnt_reg      <= ref_clr ? '0 : ref_cnt_reg + 1'b1;
      init_ref_cnt_reg <= init_ref_next;
      init_done_reg    <= init_done_next;
      test_done_reg    <= test_done_next;
      capture_reg      <= capture;
      if (capture) rd_word_reg <= SDRAM_data;
      if (capture_reg) test_pass_reg <= (rd_word_reg == TEST_PATTERN);
    end
  end

  assign clk_EN         = cke_reg;
  assign SDRAM_Addr     = addr_reg;
  assign SDRAM_BankAddr = ba_reg;
  assign {SDRAM_CHIP_Sel, SDRAM_RAS, SDRAM_CAS, SDRAM_WE} = cmd_reg;
  assign SDRAM_data     = dq_oe_reg ? TEST_PATTERN : 16'hzzzz;

endmodule

// File: tb/tb_sdram.sv
// Bench for the SDRAM controller: scoreboarded command trace through init, the
// built-in write/read-back (with a CL=2 read model) and periodic refresh.
module tb_sdram;

  localparam logic [3:0]  C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;
  localparam logic [3:0]  C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR  = 4'b0100, C_RST = 4'b1111;
  localparam int          INIT_CYC = 20000;
  localparam int          TRP = 2, TRFC = 7, TMRD = 2, TRCD = 2, CL = 2, REF_CYC = 780;
  localparam logic [15:0] PAT = 16'hA5A5;

  typedef struct {
    int          at;
    logic [3:0]  cmd;
    logic [13:0] addr;
    logic [1:0]  ba;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en;
  logic [13:0] addr;
  logic [1:0]  ba;
  wire  [15:0] dq;
  logic        we_n, cs_n, ras_n, cas_n;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_word = '0;

  int   cyc = 0;
  int   rel_base = 0;
  int   checks = 0;
  int   passed = 0;
  int   dq_bad = 0;
  int   act_cyc = 0;
  txn_t exp_q[$];

  assign dq = tb_drive ? tb_word : 16'hzzzz;

  sdram dut (
    .clk            (clk),
    .rst            (rst),
    .clk_EN         (clk_en),
    .SDRAM_Addr     (addr),
    .SDRAM_BankAddr (ba),
    .SDRAM_data     (dq),
    .SDRAM_WE       (we_n),
    .SDRAM_CHIP_Sel (cs_n),
    .SDRAM_RAS      (ras_n),
    .SDRAM_CAS      (cas_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] cmd_now();
    cmd_now = {cs_n, ras_n, cas_n, we_n};
  endfunction

  function automatic txn_t mk(input int at, input logic [3:0] c, input logic [13:0] a);
    txn_t t;
    t.at = at; t.cmd = c; t.addr = a; t.ba = 2'd0;
    return t;
  endfunction

  // Returns the next non-NOP command; tallies cycles where the DQ enable disagrees with WRITE.
  task automatic next_cmd(input int budget, output txn_t t, output bit ok);
    ok = 1'b0;
    t = mk(0, C_NOP, '0);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!tb_drive && (dut.dq_oe_reg !== (cmd_now() == C_WR))) dq_bad++;
      if (cmd_now() != C_NOP) begin
        t.at = cyc - rel_base; t.cmd = cmd_now(); t.addr = addr; t.ba = ba;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_en, cmd_now(), addr, ba, dut.dq_oe_reg, dut.test_pass_reg} !== {1'b0, C_RST, 14'h0, 2'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: cke=%b cmd=%b addr=%h ba=%0d oe=%b pass=%b, required cke=0 cmd=1111 addr=0 ba=0 oe=0 pass=0",
               clk_en, cmd_now(), addr, ba, dut.dq_oe_reg, dut.test_pass_reg);
    end else passed++;
    rst = 1'b1;
    rel_base = cyc;
    @(negedge clk);
    checks++;
    if ({clk_en, cmd_now()} !== {1'b1, C_NOP}) begin
      $display("FAIL reset_release: cke=%b cmd=%b, required cke=1 cmd=0111", clk_en, cmd_now());
    end else passed++;
  endtask

  task automatic test_mid_init_reset();
    int nonnop = 0;
    while ((cyc - rel_base) < INIT_CYC / 2) begin
      @(negedge clk);
      if (cmd_now() != C_NOP) nonnop++;
    end
    checks++;
    if (nonnop !== 0) $display("FAIL early_command: %0d non-NOP cycles, required 0", nonnop);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({clk_en, cmd_now(), addr, ba, dut.dq_oe_reg} !== {1'b0, C_RST, 14'h0, 2'd0, 1'b0}) begin
      $display("FAIL mid_init_reset: cke=%b cmd=%b addr=%h oe=%b, required cke=0 cmd=1111 addr=0 oe=0",
               clk_en, cmd_now(), addr, dut.dq_oe_reg);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    rel_base = cyc;
  endtask

  task automatic test_init();
    txn_t e, t;
    bit   ok;
    int   r1 = INIT_CYC + TRP + 1;
    exp_q.push_back(mk(INIT_CYC, C_PRE, 14'h0400));
    exp_q.push_back(mk(r1, C_REF, 14'h0));
    exp_q.push_back(mk(r1 + TRFC + 1, C_REF, 14'h0));
    exp_q.push_back(mk(r1 + 2 * (TRFC + 1), C_LMR, 14'h0020));
    dq_bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_cmd(e.at - (cyc - rel_base) + 20, t, ok);
      checks++;
      if (!ok) begin
        $display("FAIL init_timeout: no command seen, required %b at cycle %0d", e.cmd, e.at);
        exp_q.delete();
        break;
      end else passed++;
      $display("txn init cyc=%0d cmd=%b addr=%h ba=%0d", t.at, t.cmd, t.addr, t.ba);
      checks++;
      if ({t.cmd, t.ba, t.addr} !== {e.cmd, e.ba, e.addr})
        $display("FAIL init_cmd: cmd=%b addr=%h ba=%0d, required cmd=%b addr=%h ba=%0d", t.cmd, t.addr, t.ba, e.cmd, e.addr, e.ba);
      else passed++;
      checks++;
      if (t.at !== e.at) $display("FAIL init_cycle: %b at %0d, required %0d", t.cmd, t.at, e.at);
      else passed++;
    end
    checks++;
    if (dq_bad !== 0) $display("FAIL init_dq_enable: %0d bad cycles, required 0", dq_bad);
    else passed++;
  endtask

  task automatic test_write_read();
    txn_t e, t;
    bit   ok;
    act_cyc = INIT_CYC + TRP + 1 + 2 * (TRFC + 1) + TMRD + 1;
    exp_q.push_back(mk(act_cyc, C_ACT, 14'h0));
    exp_q.push_back(mk(act_cyc + TRCD + 1, C_WR, 14'h0400));
    exp_q.push_back(mk(act_cyc + TRCD + 1 + TRP + 3, C_ACT, 14'h0));
    exp_q.push_back(mk(act_cyc + 2 * (TRCD + 1) + TRP + 3, C_RD, 14'h0400));
    dq_bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_cmd(e.at - (cyc - rel_base) + 20, t, ok);
      checks++;
      if (!ok) begin
        $display("FAIL rw_timeout: no command seen, required %b at cycle %0d", e.cmd, e.at);
        exp_q.delete();
        break;
      end else passed++;
      $display("txn rw   cyc=%0d cmd=%b addr=%h ba=%0d dq=%h", t.at, t.cmd, t.addr, t.ba, dq);
      checks++;
      if ({t.cmd, t.ba, t.addr} !== {e.cmd, e.ba, e.addr})
        $display("FAIL rw_cmd: cmd=%b addr=%h ba=%0d, required cmd=%b addr=%h ba=%0d", t.cmd, t.addr, t.ba, e.cmd, e.addr, e.ba);
      else passed++;
      checks++;
      if (t.at !== e.at) $display("FAIL rw_cycle: %b at %0d, required %0d", t.cmd, t.at, e.at);
      else passed++;
      if (t.cmd == C_WR) begin
        checks++;
        if (dq !== PAT) $display("FAIL write_data: dq=%h, required %h", dq, PAT);
        else passed++;
      end
      if (t.cmd == C_RD) begin
        // Device model: data valid at the CL-th edge after the device samples READ
        repeat (CL) @(posedge clk);
        #1 tb_word = PAT;
        tb_drive = 1'b1;
        @(posedge clk);
        #1 tb_drive = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dut.rd_word_reg !== PAT) $display("FAIL read_word: rd_word=%h, required %h", dut.rd_word_reg, PAT);
    else passed++;
    checks++;
    if (dut.test_pass_reg !== 1'b1) $display("FAIL test_pass: got %b, required 1", dut.test_pass_reg);
    else passed++;
    checks++;
    if (dq_bad !== 0) $display("FAIL rw_dq_enable: %0d bad cycles, required 0", dq_bad);
    else passed++;
  endtask

  task automatic test_periodic_refresh();
    txn_t e, t;
    bit   ok;
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk(act_cyc + k * REF_CYC, C_REF, 14'h0));
    dq_bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_cmd(e.at - (cyc - rel_base) + 20, t, ok);
      checks++;
      if (!ok) begin
        $display("FAIL refresh_timeout: no command seen, required REFRESH at cycle %0d", e.at);
        exp_q.delete();
        break;
      end else passed++;
      $display("txn ref  cyc=%0d cmd=%b addr=%h ba=%0d", t.at, t.cmd, t.addr, t.ba);
      checks++;
      if ({t.cmd, t.ba, t.addr} !== {e.cmd, e.ba, e.addr})
        $display("FAIL refresh_cmd: cmd=%b addr=%h, required cmd=%b addr=%h", t.cmd, t.addr, e.cmd, e.addr);
      else passed++;
      checks++;
      if (t.at !== e.at) $display("FAIL refresh_cycle: REFRESH at %0d, required %0d", t.at, e.at);
      else passed++;
    end
    checks++;
    if (dq_bad !== 0) $display("FAIL refresh_dq_enable: %0d bad cycles, required 0", dq_bad);
    else passed++;
  endtask

  task automatic test_final_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({clk_en, cmd_now(), dut.test_pass_reg} !== {1'b0, C_RST, 1'b0})
      $display("FAIL final_reset: cke=%b cmd=%b pass=%b, required cke=0 cmd=1111 pass=0", clk_en, cmd_now(), dut.test_pass_reg);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mid_init_reset();
    test_init();
    test_write_read();
    test_periodic_refresh();
    test_final_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
